tmr_vote_monitor: RTL
=====================

Name: tmr_vote_monitor

Overview:
- Sits directly downstream of the 2-bit triple-modular-redundancy voter.
- Consumes the voted value and the voter's disagreement flag, and registers the voted value for the rest of the datapath.
- While the voter reports disagreement, the output holds the last good value.
- Counts consecutive and total disagreements, and raises a sticky fault once a run of disagreements reaches a threshold. The fault is cleared only by a req/ack handshake.

Parameters:
- WIDTH, 2, width of the voted data word (matches voter output).
- TRIP_COUNT, 4, consecutive erroneous valid samples that trip the fault (legal range 1..255).
- CNT_W, 8, width of the total-error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- voted_in  input  WIDTH  voted value from the voter.
- vote_error  input  1  voter disagreement flag (1 = no two replicas agreed).
- vote_valid  input  1  voted_in/vote_error are meaningful this cycle.
- clear_req  input  1  request to clear the fault and the counters; level, held until ack.
- clear_ack  output  1  one-cycle pulse acknowledging clear_req.
- data_out  output  WIDTH  last good voted value.
- data_valid  output  1  one-cycle pulse when data_out takes a new good sample.
- hold  output  1  high while data_out is frozen due to disagreement (state SUSPECT or FAULT).
- fault  output  1  sticky fault flag.
- err_total  output  CNT_W  saturating count of erroneous valid samples since reset or clear.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state = OK, run counter = 0, err_total = 0;
  - data_out = 0, data_valid = 0, hold = 0, fault = 0, clear_ack = 0.
- Reset overrides every other input, including mid-handshake and while in FAULT.
- The FSM has three states: OK, SUSPECT and FAULT. All outputs are registered.
- Good sample (vote_valid=1, vote_error=0) in OK or SUSPECT:
  - data_out <= voted_in and data_valid = 1 on the next cycle (latency 1);
  - run counter <= 0; state <= OK; hold <= 0.
- Bad sample (vote_valid=1, vote_error=1) in OK or SUSPECT:
  - data_out unchanged; data_valid = 0; run counter increments; err_total increments.
  - If the new run count equals TRIP_COUNT: state <= FAULT and fault <= 1.
  - Otherwise: state <= SUSPECT.
  - hold <= 1 in either case.
- With TRIP_COUNT=1, the first bad sample goes directly OK -> FAULT.
- vote_valid=0: no state or counter change; data_valid = 0.
- FAULT state:
  - data_out frozen, hold = 1, fault = 1; good samples are ignored.
  - Bad samples still increment err_total; the run counter stops at TRIP_COUNT.
- err_total saturates at 2^CNT_W-1 and never wraps.
- Clear handshake:
  - When clear_req=1 and clear_ack was 0 in the previous cycle: clear_ack = 1 for exactly one cycle.
  - In that same edge: state <= OK, run counter <= 0, err_total <= 0, fault <= 0, hold <= 0.
  - data_out keeps its value.
  - If clear_req stays high, the next ack is issued no sooner than 2 cycles later (ack low for at least one cycle between pulses).
  - Clear is accepted in any state.
- Simultaneous clear_req and vote_valid on the same edge: clear wins and the sample is discarded (no data_valid, no counting).
- Only consecutive valid samples form a run. Invalid cycles between bad samples do not break the run; a good sample does.

Test Plan:
- Reset, then good samples 2'b01, 2'b10 on consecutive cycles -> data_out = 01 then 10, each one cycle after input; data_valid pulses twice; hold=0; fault=0; err_total=0.
- After data_out=10: bad, bad, then good 2'b11 -> data_out stays 10 and hold=1 for 2 cycles; then data_out=11, hold=0, err_total=2, fault=0.
- 4 consecutive bad samples (TRIP_COUNT=4), with idle cycles interleaved -> fault=1 after the 4th; good 2'b00 afterwards is ignored (data_out unchanged); err_total=4.
- In FAULT, assert clear_req together with vote_valid good 2'b01 -> clear_ack pulses 1 cycle; fault=0, err_total=0, state OK; sample discarded (no data_valid).
- CNT_W=2, 5 bad samples with a good sample between each -> err_total saturates at 3; fault never sets.
- rst asserted while in SUSPECT with clear_req high -> all outputs 0 next cycle; no clear_ack.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// -----------------------------------------------------------------------------
// tmr_vote_monitor
// Post-voter monitor for a triple-modular-redundancy datapath. Registers the
// voted word for downstream logic and freezes it while the voter reports
// disagreement. It tracks the current run of erroneous samples and a
// saturating total, and latches a sticky fault once the run reaches
// TRIP_COUNT. Fault and counters are cleared only through a req/ack handshake.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_voted_in    voted value from the voter                      [WIDTH]
//   i_vote_error  voter disagreement flag (1 = no majority)
//   i_vote_valid  voted_in / vote_error meaningful this cycle
//   i_clear_req   level request to clear fault and counters
//   o_clear_ack   one-cycle acknowledge of i_clear_req
//   o_data_out    last good voted value                           [WIDTH]
//   o_data_valid  one-cycle pulse when o_data_out takes a good sample
//   o_hold        data frozen (SUSPECT or FAULT)
//   o_fault       sticky fault flag
//   o_err_total   saturating count of erroneous valid samples     [CNT_W]
// -----------------------------------------------------------------------------
module tmr_vote_monitor #(
   parameter int WIDTH      = 2,
   parameter int TRIP_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_voted_in,
   input  logic             i_vote_error,
   input  logic             i_vote_valid,
   input  logic             i_clear_req,
   output logic             o_clear_ack,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_data_valid,
   output logic             o_hold,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_err_total
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   // Run counter is 8 bits because TRIP_COUNT is limited to 1..255.
   localparam logic [7:0] TRIP = TRIP_COUNT[7:0];

   state_t           r_state;
   logic [7:0]       r_run;
   logic [CNT_W-1:0] r_err_total;
   logic [WIDTH-1:0] r_data_out;
   logic             r_data_valid;
   logic             r_hold;
   logic             r_fault;
   logic             r_clear_ack;

   logic             w_clear_take;
   logic [7:0]       w_run_next;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // A new ack is only granted if none was issued last cycle, which forces
   // at least one low cycle between acks while the request stays high.
   assign w_clear_take = i_clear_req & ~r_clear_ack;
   assign w_run_next   = r_run + 8'd1;

   // Monitor FSM, counters and all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_OK;
         r_run        <= 8'd0;
         r_err_total  <= {CNT_W{1'b0}};
         r_data_out   <= {WIDTH{1'b0}};
         r_data_valid <= 1'b0;
         r_hold       <= 1'b0;
         r_fault      <= 1'b0;
         r_clear_ack  <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_clear_ack  <= 1'b0;
         if (w_clear_take) begin
            // Clear has priority over a coincident sample, which is dropped.
            // The last good data word is deliberately retained.
            r_clear_ack <= 1'b1;
            r_state     <= ST_OK;
            r_run       <= 8'd0;
            r_err_total <= {CNT_W{1'b0}};
            r_fault     <= 1'b0;
            r_hold      <= 1'b0;
         end else if (i_vote_valid) begin
            case (r_state)
               ST_OK, ST_SUSPECT: begin
                  if (!i_vote_error) begin
                     r_data_out   <= i_voted_in;
                     r_data_valid <= 1'b1;
                     r_run        <= 8'd0;
                     r_state      <= ST_OK;
                     r_hold       <= 1'b0;
                  end else begin
                     r_run       <= w_run_next;
                     r_err_total <= sat_inc(r_err_total);
                     r_hold      <= 1'b1;
                     if (w_run_next == TRIP) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                     end else begin
                        r_state <= ST_SUSPECT;
                     end
                  end
               end
               ST_FAULT: begin
                  // Good samples are ignored; the run counter rests at TRIP.
                  if (i_vote_error) begin
                     r_err_total <= sat_inc(r_err_total);
                  end else begin
                     r_err_total <= r_err_total;
                  end
               end
               default: begin
                  r_state <= ST_OK;
                  r_run   <= 8'd0;
               end
            endcase
         end else begin
            // Idle cycle: nothing changes, so an idle gap does not break a run.
            r_state <= r_state;
         end
      end
   end

   assign o_clear_ack  = r_clear_ack;
   assign o_data_out   = r_data_out;
   assign o_data_valid = r_data_valid;
   assign o_hold       = r_hold;
   assign o_fault      = r_fault;
   assign o_err_total  = r_err_total;

endmodule
